// File: rtl/i2s_rx_stream_module_pkg.sv
// i2s_pkg: shared FSM encoding and default sizing for the I2S stream stage
package i2s_pkg;
  localparam int DATA_RES_D = 24;
  localparam int DEPTH_D = 4;
  localparam int CAP_DLY_D = 8;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {DISARM, IDLE, DELAY, CAPTURE} state_e;
endpackage

// File: rtl/i2s_rx_stream_module_if.sv
// i2s_rx_stream_module_if: sample-pair stream with valid/ready and occupancy
interface i2s_rx_stream_module_if
  import i2s_pkg::*;
#(
  parameter int DATA_RES = DATA_RES_D,
  parameter int DEPTH = DEPTH_D
);
  logic [DATA_RES-1:0] left_o;
  logic [DATA_RES-1:0] right_o;
  logic valid_o;
  logic ready_i;
  logic [$clog2(DEPTH):0] level_o;
  modport master (output left_o, right_o, valid_o, level_o, input ready_i);
  modport slave (input left_o, right_o, valid_o, level_o, output ready_i);
endinterface

// File: rtl/i2s_rx_stream_module_sync_fifo.sv
// sync_fifo_module: wrap-bit pointer FIFO with a registered head (no fall-through)
module sync_fifo_module #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic [WIDTH-1:0] wdata,
  input  logic pop,
  output logic [WIDTH-1:0] rdata,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [AW:0] w_rd_nxt;
  logic w_pop, w_push;
  assign level = r_wr - r_rd;
  assign empty = r_wr == r_rd;
  assign full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign w_rd_nxt = r_rd + (AW+1)'(1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
      rdata <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= w_rd_nxt;
      // head takes the incoming word whenever it becomes the only entry
      if (w_push && (empty || (w_pop && level == (AW+1)'(1)))) rdata <= wdata;
      else if (w_pop) rdata <= r_mem[w_rd_nxt[AW-1:0]];
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/i2s_rx_stream_module.sv
// i2s_rx_stream_module: lrck-timed capture of L/R pairs into a FIFO-backed stream
module i2s_rx_stream_module
  import i2s_pkg::*;
#(
  parameter int DATA_RES = DATA_RES_D,
  parameter int DEPTH = DEPTH_D,
  parameter int CAP_DLY = CAP_DLY_D
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lrck_i,
  input  logic [DATA_RES-1:0] left_i,
  input  logic [DATA_RES-1:0] right_i,
  input  logic clr_i,
  output logic ovf_o,
  i2s_rx_stream_module_if.master s
);
  logic r_s1, r_s2, r_s3;
  state_e r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_ovf;
  logic w_rise, w_fall, w_push, w_pop, w_drop, w_empty, w_full;
  logic [2*DATA_RES-1:0] w_rdata;
  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_push = r_state == CAPTURE;
  assign w_pop = s.valid_o & s.ready_i;
  assign w_drop = w_push & w_full & ~w_pop;
  assign s.valid_o = ~w_empty;
  assign s.left_o = w_rdata[2*DATA_RES-1:DATA_RES];
  assign s.right_o = w_rdata[DATA_RES-1:0];
  assign ovf_o = r_ovf;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {r_s1, r_s2, r_s3} <= '0;
      r_state <= DISARM;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      {r_s1, r_s2, r_s3} <= {lrck_i, r_s1, r_s2};
      r_ovf <= w_drop | (r_ovf & ~clr_i);
      // DISARM waits for a fall so the first captured pair is a whole frame
      unique case (r_state)
        DISARM: if (w_fall) r_state <= IDLE;
        IDLE: if (w_rise) begin
          r_state <= DELAY;
          r_cnt <= '0;
        end
        DELAY: if (w_rise) r_cnt <= '0;
          else if (r_cnt == CNT_W'(CAP_DLY - 1)) r_state <= CAPTURE;
          else r_cnt <= r_cnt + CNT_W'(1);
        CAPTURE: r_state <= IDLE;
      endcase
    end
  end
  sync_fifo_module #(.WIDTH(2*DATA_RES), .DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(w_push),
    .wdata({left_i, right_i}),
    .pop(w_pop),
    .rdata(w_rdata),
    .empty(w_empty),
    .full(w_full),
    .level(s.level_o)
  );
endmodule

// File: tb/tb_i2s_rx_stream_module.sv
// tb_i2s_rx_stream_module: directed + randomized frames checked against a queue model
module tb_i2s_rx_stream_module;
  import i2s_pkg::*;
  localparam int DR = DATA_RES_D;
  localparam int DP = DEPTH_D;
  localparam int CD = CAP_DLY_D;
  logic clk = 1'b0, rst = 1'b1, lrck = 1'b0, clr = 1'b0, ready = 1'b0;
  logic [DR-1:0] left = '0, right = '0;
  logic ovf;
  i2s_rx_stream_module_if bus ();
  assign bus.ready_i = ready;
  i2s_rx_stream_module dut (
    .clk_i(clk), .rst_i(rst), .lrck_i(lrck), .left_i(left), .right_i(right),
    .clr_i(clr), .ovf_o(ovf), .s(bus)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0, cyc = 0, push_cyc = 0;
  logic [2*DR-1:0] q[$];
  bit ovf_m = 0, armed = 0, prev = 0, pend = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a pair is pushed 3+CAP_DLY edges after the first edge that samples lrck high,
  // provided a falling lrck has been seen since reset
  task automatic model_edge();
    bit p_pop, p_push, p_drop;
    if (rst) begin
      q.delete();
      {ovf_m, armed, prev, pend} = '0;
    end else begin
      p_pop = q.size() > 0 && ready;
      p_push = pend && cyc == push_cyc;
      if (p_push) pend = 0;
      p_drop = p_push && q.size() == DP && !p_pop;
      if (p_pop) void'(q.pop_front());
      if (p_push && !p_drop) q.push_back({left, right});
      ovf_m = p_drop ? 1'b1 : clr ? 1'b0 : ovf_m;
      if (lrck && !prev && armed) begin
        pend = 1;
        push_cyc = cyc + 3 + CD;
      end
      if (!lrck && prev) armed = 1;
      prev = lrck;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("valid", bus.valid_o, q.size() > 0);
    chk("level", bus.level_o, q.size());
    chk("ovf", ovf, ovf_m);
    if (q.size() > 0) chk("head", {bus.left_o, bus.right_o}, q[0]);
  endtask

  task automatic frame(input logic [DR-1:0] l, r, input int hi, lo, clr_at, rdy_at, input bit rnd);
    left = l;
    right = r;
    lrck = 1'b1;
    for (int i = 1; i <= hi + lo; i++) begin
      if (i == hi + 1) lrck = 1'b0;
      if (rnd) ready = 1'($urandom_range(0, 1));
      clr = (i == clr_at);
      if (i == rdy_at) ready = 1'b1;
      step();
      if (i == rdy_at) ready = 1'b0;
    end
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lrck = 1'b1;
    repeat (3) step();
    chk("rst_head", {bus.left_o, bus.right_o}, 0);
    chk("rst_valid", bus.valid_o, 0);
    rst = 1'b0;
    repeat (20) step();
    chk("arm_none", bus.level_o, 0);
    lrck = 1'b0;
    repeat (16) step();
    frame(24'h123456, 24'hABCDEF, 16, 16, 0, 0, 0);
    chk("basic_left", bus.left_o, 24'h123456);
    chk("basic_right", bus.right_o, 24'hABCDEF);
    chk("basic_valid", bus.valid_o, 1);
    chk("basic_level", bus.level_o, 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("basic_pop", bus.level_o, 0);
    for (int i = 1; i <= 5; i++) frame(DR'(i), DR'($urandom), 16, 16, 0, 0, 0);
    chk("ovf_level", bus.level_o, 4);
    chk("ovf_set", ovf, 1);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", bus.left_o, i);
      step();
    end
    ready = 1'b0;
    chk("ovf_sticky", ovf, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    for (int i = 11; i <= 14; i++) frame(DR'(i), DR'($urandom), 16, 16, 0, 0, 0);
    frame(DR'(6), DR'($urandom), 16, 16, 12, 0, 0);
    chk("clr_vs_drop", ovf, 1);
    chk("drop_level", bus.level_o, 4);
    clr = 1'b1;
    step();
    clr = 1'b0;
    frame(DR'(7), DR'($urandom), 16, 16, 0, 12, 0);
    chk("fullpop_level", bus.level_o, 4);
    chk("fullpop_ovf", ovf, 0);
    chk("fullpop_head", bus.left_o, 12);
    ready = 1'b1;
    repeat (6) step();
    ready = 1'b0;
    frame(DR'(21), DR'($urandom), 16, 16, 0, 0, 0);
    frame(DR'(22), DR'($urandom), 16, 16, 0, 0, 0);
    chk("mid_level", bus.level_o, 2);
    left = DR'(23);
    lrck = 1'b1;
    repeat (6) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("mid_valid", bus.valid_o, 0);
    chk("mid_flush", bus.level_o, 0);
    repeat (10) step();
    lrck = 1'b0;
    repeat (16) step();
    chk("abort_none", bus.level_o, 0);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) frame(DR'(100 + i), DR'($urandom), 16, 16, 0, 0, 0);
    chk("stream_ovf", ovf, 0);
    for (int i = 0; i < 20; i++)
      frame(DR'($urandom), DR'($urandom), $urandom_range(14, 24), $urandom_range(14, 24), 0, 0, 1);
    ready = 1'b1;
    repeat (8) step();
    chk("final_empty", bus.valid_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2s_rx_stream_module.md
# i2s_rx_stream_module

Downstream stage of the I2S receiver core. Transfers each completed left/right sample pair from the bit-clock domain into the system clock domain, buffers pairs in a small FIFO, and presents them on a valid/ready stream. It synchronises the raw word-select line, waits a programmable settling delay, then captures both channels together. FIFO overflow is flagged with a sticky error bit.

## Interface
- DATA_RES, 24: sample width per channel; must match the receiver core.
- DEPTH, 4: number of FIFO entries; power of two, ≥ 2.
- CAP_DLY, 8: settling delay in clk_i cycles between the synchronised lrck rising edge and capture; 1..255.

- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous to clk_i, active-high.
- lrck_i  in  1  raw word-select from the pad, asynchronous to clk_i.
- left_i  in  DATA_RES  left sample from the receiver core (bck domain).
- right_i  in  DATA_RES  right sample from the receiver core (bck domain).
- left_o  out  DATA_RES  left sample at the FIFO head.
- right_o  out  DATA_RES  right sample at the FIFO head.
- valid_o  out  1  FIFO non-empty; head pair is valid.
- ready_i  in  1  consumer accepts the head pair when valid_o && ready_i.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf_o  out  1  sticky overflow flag.
- clr_i  in  1  clears ovf_o.

## Operation
- **Synchroniser:** lrck_i passes through flops s1→s2→s3, all reset to 0.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- **FSM, encoded in the package enum:**
  - DISARM (reset state): goes to IDLE on fall. This guarantees the first captured pair is complete, even if lrck is high when reset releases.
  - IDLE: on rise, load cnt=0 and go to DELAY.
  - DELAY: increment cnt each cycle. When cnt==CAP_DLY-1, go to CAPTURE. A new rise while in DELAY reloads cnt=0 and stays in DELAY.
  - CAPTURE: one cycle. Registers {left_i,right_i} into the FIFO write path (push), then returns to IDLE.
  - cnt width is 8 bits.
- **Data coherency:** left_i and right_i are sampled only in CAPTURE. The system-level constraint is that (3+CAP_DLY) clk_i periods must exceed 2 bck periods and be less than half an lrck period. Both buses are then static when sampled.
- **FIFO:**
  - Storage is DEPTH × 2·DATA_RES.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide with wrap-bit full/empty detection.
  - The head is a registered output with no fall-through. A push into an empty FIFO sets valid_o on the following edge.
  - pop = valid_o && ready_i.
  - Simultaneous push and pop while full: both are performed, level is unchanged, and no overflow is raised.
  - Simultaneous push and pop while empty: the push is performed and the pop is not.
  - Push while full without a pop: the new pair is dropped, FIFO contents are unchanged, and ovf_o is set.
- **ovf_o:**
  - Set on a dropped push; cleared by clr_i.
  - If clr_i and a drop occur in the same cycle, set wins.
- **Reset values:**
  - valid_o=0, level_o=0, ovf_o=0.
  - left_o and right_o are all zeros.
  - Pointers are 0, and the FSM is in DISARM.
- **Reset mid-operation:** reset in any state flushes the FIFO and aborts any pending capture. After release the block re-arms only on the next fall.

## Timing
- Edge k is the first clk_i edge at which s1 samples lrck_i=1.
  - s3 goes high at edge k+2.
  - DELAY is entered at edge k+2.
  - CAPTURE is active after edge k+2+CAP_DLY.
  - The push completes at edge k+3+CAP_DLY.
- With an empty FIFO, valid_o rises and level_o becomes 1 after edge k+3+CAP_DLY.
- Pop latency: the pair accepted at edge n is replaced by the next entry, or valid_o falls, after edge n. level_o updates on the same edge.
- There is one capture per lrck period; the maximum sustained push rate equals the frame rate.

## Structure
- **Package i2s_pkg:**
  - The FSM enum: DISARM, IDLE, DELAY, CAPTURE.
  - The default DATA_RES, DEPTH and CAP_DLY constants.
  - The counter width constant CNT_W=8.
- **Sub-module sync_fifo_module:**
  - Parameterised by WIDTH=2·DATA_RES and DEPTH.
  - Ports: clk_i, rst_i, push, wdata, pop, rdata, empty, full, level.
- The top level holds the synchroniser, the FSM/counter, the capture register and the ovf logic.

## Test plan
- **Basic capture:** reset released with lrck=0; drive left=24'h123456, right=24'hABCDEF. Raise lrck at edge k (CAP_DLY=8) → push at edge k+11; left_o=24'h123456, right_o=24'hABCDEF, valid_o=1, level_o=1.
- **Arming:** hold lrck=1 through reset release → no push until lrck falls and then rises again.
- **Overflow:** DEPTH=4, ready_i=0, 5 frames with left=1..5 → level_o=4, ovf_o=1. Then pops return 1,2,3,4. clr_i drops ovf_o on the next edge, and clr_i coincident with a 6th drop leaves ovf_o=1.
- **Full with simultaneous pop:** full FIFO with ready_i=1 on the push edge → no overflow, level_o stays 4, FIFO order preserved.
- **Reset mid-operation:** rst_i asserted during DELAY with 2 entries held → valid_o=0, level_o=0, and no capture from the aborted edge.
- **Back-to-back stream:** ready_i=1, 16 frames with incrementing data → every pair is emitted once, in order, ovf_o=0.
